// File: rtl/ps2_rx_if.sv
// Scan-code output handshake between ps2_rx and its consumer.
// One byte is held while rx_valid is high. It is consumed when rx_ready is also high.
interface ps2_rx_if;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;

  // Receiver side: presents the byte and observes consumer readiness.
  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  // Consumer side: observes the byte and signals acceptance.
  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver.
// The block synchronises the raw PS/2 clock and data pins and deglitches the clock.
// It shifts in 11-bit frames on filtered falling edges and checks start, odd parity
// and stop. Each good byte is presented on a one-entry valid/ready register.
// A partial frame is abandoned if the PS/2 clock goes quiet for TIMEOUT_CYCLES.
module ps2_rx #(
  parameter int FILTER_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic      clk,
  input  logic      reset_low,
  input  logic      ps2_clk_pin,
  input  logic      ps2_data_pin,
  ps2_rx_if.master  rx
);

  localparam int FILT_W = (FILTER_CYCLES  > 1) ? $clog2(FILTER_CYCLES)  : 1;
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        LAST_BIT = 4'd10;

  // Two-flop synchronisers; idle PS/2 lines are high
  logic clk_s1_q, clk_s2_q;
  logic dat_s1_q, dat_s2_q;

  // Clock deglitch filter
  logic              filt_clk_q, filt_clk_d;
  logic              filt_prev_q;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              fall_edge;

  // Frame deserialiser
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [9:0]        shreg_q, shreg_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [10:0]       frame_w;
  logic              frame_good;

  // Output register
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       held_block;

  // Bring both asynchronous pins into the clk domain
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_pin;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_pin;
      dat_s2_q <= dat_s1_q;
    end
  end

  // The filtered clock follows only after a new level has held for FILTER_CYCLES cycles
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_MAX) begin
        filt_clk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end
  end

  // The previous filtered level turns a 1->0 change into a single-cycle capture strobe
  assign fall_edge = filt_prev_q & ~filt_clk_q;

  // Filter state registers
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_clk_q  <= filt_clk_d;
      filt_prev_q <= filt_clk_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // Shift in bits LSB first. Check the frame on the 11th bit. Drop a stalled partial frame.
  always_comb begin
    // frame_w[0]=start, [8:1]=data, [9]=parity, [10]=stop once all 11 bits are in
    frame_w    = {dat_s2_q, shreg_q};
    frame_good = fall_edge && (bit_cnt_q == LAST_BIT) &&
                 !frame_w[0] && frame_w[10] && (^frame_w[9:1]);
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    idle_cnt_d = '0;
    if (fall_edge) begin
      shreg_d   = frame_w[10:1];
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? 4'd0 : bit_cnt_q + 4'd1;
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_cnt_q == IDLE_MAX) begin
        bit_cnt_d = 4'd0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end
  end

  // Deserialiser state registers
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      bit_cnt_q  <= 4'd0;
      shreg_q    <= '0;
      idle_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Load a good byte unless an unconsumed byte is still held. In that case the new byte is lost.
  always_comb begin
    held_block = rx_valid_q && !rx.rx_ready;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (frame_good && !held_block) begin
      rx_valid_d = 1'b1;
      rx_data_d  = frame_w[8:1];
    end else if (rx_valid_q && rx.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx.rx_valid = rx_valid_q;
  assign rx.rx_data  = rx_data_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed PS/2 frames with a scoreboard of expected bytes.
module tb_ps2_rx;
  localparam int FILT = 16;
  localparam int TMO  = 200;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic reset_low;
  logic ps2_clk_pin;
  logic ps2_data_pin;

  ps2_rx_if rx_if ();

  ps2_rx #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset_low    (reset_low),
    .ps2_clk_pin  (ps2_clk_pin),
    .ps2_data_pin (ps2_data_pin),
    .rx           (rx_if)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set while the clock is high, then a clock low phase.
  // An optional short low glitch is placed in the high phase.
  task automatic send_bit(input logic b, input int glitch);
    ps2_data_pin = b;
    cyc(10);
    if (glitch > 0) begin
      ps2_clk_pin = 1'b0;
      cyc(glitch);
      ps2_clk_pin = 1'b1;
      cyc(20);
    end
    ps2_clk_pin = 1'b0;
    cyc(HALF);
    ps2_clk_pin = 1'b1;
    cyc(HALF - 10);
  endtask

  // g=0 no glitches, g=1 widths FILT-1 down to FILT-11, g=2 widths 1 up to 11
  task automatic send_bits(input logic [10:0] bits, input int n, input int g);
    for (int i = 0; i < n; i++) begin
      send_bit(bits[i], (g == 1) ? (FILT - 1 - i) : (g == 2) ? (1 + i) : 0);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int g);
    send_bits({stop, par, d, 1'b0}, 11, g);
    ps2_data_pin = 1'b1;
    cyc(50);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc(1);
      n++;
    end
    check(name, {7'd0, (exp_q.size() == 0)}, 8'd1);
  endtask

  // Scoreboard monitor: pop on every consumed byte and check that a held byte stays stable
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (reset_low) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", {7'd0, rx_if.rx_valid}, 8'd1);
        check("hold_data", rx_if.rx_data, prev_data);
      end
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL byte_unexpected actual=%h required=none", rx_if.rx_data);
        end else begin
          check("byte", rx_if.rx_data, exp_q.pop_front());
        end
      end
      prev_valid = rx_if.rx_valid;
      prev_ready = rx_if.rx_ready;
      prev_data  = rx_if.rx_data;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = 8'h00;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ps2_clk_pin    = 1'b1;
    ps2_data_pin   = 1'b1;
    rx_if.rx_ready = 1'b1;
    reset_low      = 1'b0;
    cyc(5);
    check("reset_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    check("reset_data", rx_if.rx_data, 8'h00);
    reset_low = 1'b1;
    cyc(5);

    // Single good frame
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    wait_drain("single_drain");
    check("single_valid_clear", {7'd0, rx_if.rx_valid}, 8'd0);

    // Backpressure and overrun
    rx_if.rx_ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    check("bp_valid_first", {7'd0, rx_if.rx_valid}, 8'd1);
    check("bp_data_first", rx_if.rx_data, 8'h5A);
    send_frame(8'hF0, 1'b1, 1'b1, 0);
    check("bp_valid_overrun", {7'd0, rx_if.rx_valid}, 8'd1);
    check("bp_data_overrun", rx_if.rx_data, 8'h5A);
    rx_if.rx_ready = 1'b1;
    cyc(1);
    check("bp_valid_clear", {7'd0, rx_if.rx_valid}, 8'd0);
    wait_drain("bp_drain");

    // Framing errors, then a good frame
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    check("bad_parity_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    check("bad_stop_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    wait_drain("after_errors_drain");

    // Glitch rejection on the clock line
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    wait_drain("glitch_desc_drain");
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 1'b1, 2);
    wait_drain("glitch_asc_drain");

    // Timeout of a 5-bit partial frame
    send_bits(11'b111_1111_1110, 5, 0);
    ps2_data_pin = 1'b1;
    cyc(300);
    exp_q.push_back(8'h29);
    send_frame(8'h29, 1'b0, 1'b1, 0);
    wait_drain("timeout_drain");

    // Reset in the middle of a frame
    send_bits({1'b1, 1'b1, 8'h12, 1'b0}, 6, 0);
    #3;
    reset_low = 1'b0;
    #1;
    check("midreset_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    check("midreset_data", rx_if.rx_data, 8'h00);
    cyc(3);
    reset_low    = 1'b1;
    ps2_data_pin = 1'b1;
    cyc(20);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b1, 0);
    wait_drain("midreset_drain");

    cyc(20);
    check("final_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
